mlp_layer_tm: RTL and testbench
===============================

// Module: mlp_layer_tm
// PURPOSE
//  Time-multiplexed binary fully-connected layer: neuron n fires when popcount(XNOR(in_vector, W[n])) >= T[n].
//  One weight chunk is processed per cycle instead of instantiating every neuron in parallel.
//  Weights and thresholds are read from external storage; input and result use valid/ready handshakes.
//  The layer sits between the flatten/conv stages and the next layer or argmax in the BNN datapath.
// PARAMETERS
//  INPUT_SIZE      784                       binary inputs per vector
//  NUM_NEURONS     10                        neurons (output bits)
//  CHUNK           16                        input bits XNOR-popcounted per cycle
//  THRESHOLD_WIDTH $clog2(INPUT_SIZE+1)      threshold / accumulator width
//  (derived) NCHUNK = ceil(INPUT_SIZE/CHUNK); AW = $clog2(NUM_NEURONS*NCHUNK)
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 asynchronous reset, active low
//  in_valid   in   1                 in_vector valid
//  in_ready   out  1                 layer idle, can accept a vector
//  in_vector  in   INPUT_SIZE        binary input vector
//  wt_addr    out  AW                weight word address = neuron*NCHUNK + chunk
//  wt_data    in   CHUNK             combinational read data; weights for in_vector[chunk*CHUNK +: CHUNK]
//  thr_addr   out  $clog2(NUM_NEURONS) current neuron index
//  thr_data   in   THRESHOLD_WIDTH   combinational threshold read for thr_addr
//  busy       out  1                 computing (state ACCUM)
//  out_valid  out  1                 out_vector valid
//  out_ready  in   1                 downstream accepts result
//  out_vector out  NUM_NEURONS       neuron output bits, bit n = neuron n
// BEHAVIOUR
//  Reset: FSM enters IDLE; in_ready=1; busy=0; out_valid=0; out_vector=0; counters/accumulator=0.
//  Reset is honoured at any time: a mid-computation reset aborts and drops the vector.
//  FSM states are IDLE, ACCUM, DONE.
//   IDLE: in_ready=1. On in_valid: latch in_vector; clear neuron=0, chunk=0, acc=0; go to ACCUM.
//   ACCUM: in_ready=0, busy=1. Each cycle:
//    - acc += popcount(~(in_chunk ^ wt_data) & mask).
//    - mask clears bit positions >= INPUT_SIZE in the last chunk; padding never counts.
//    - On chunk==NCHUNK-1: out_vector[neuron] <= (acc+partial >= thr_data); acc <= 0; chunk <= 0.
//    - Otherwise chunk++.
//    - Last chunk of neuron NUM_NEURONS-1 goes to DONE; any other neuron does neuron++.
//   DONE: out_valid=1. out_vector is stable. On out_ready go to IDLE, so in_ready=1 the next cycle.
//  Timing and ordering:
//   - out_valid rises exactly NUM_NEURONS*NCHUNK clocks after the accepting edge.
//   - No overlap between vectors: in_valid is ignored outside IDLE.
//   - wt_addr/thr_addr are driven from registered counters.
//   - wt_data/thr_data are sampled in the same cycle.
//   - Addresses are don't-care outside ACCUM but must hold 0 after reset.
//  Arithmetic:
//   - Accumulator is THRESHOLD_WIDTH bits; it cannot overflow (max INPUT_SIZE).
//   - Compare is unsigned. thr=0 -> bit always 1; thr > INPUT_SIZE -> bit always 0.
//  out_vector bits update per neuron during ACCUM; they are only meaningful while out_valid=1.
// CONFIGURATION
//  MLP_LAYER_SCORE_OUT_EN defined:
//   - Adds output port scores [NUM_NEURONS*THRESHOLD_WIDTH] (reset 0).
//   - Slice n latches neuron n's final popcount when its bit is written.
//   - The slice stays valid with out_valid; it is intended for an argmax output layer.
//  MLP_LAYER_SCORE_OUT_EN not defined: the port and its registers do not exist; behaviour is otherwise identical.
// TESTING
//  The bench uses INPUT_SIZE=20, NUM_NEURONS=3, CHUNK=8 (NCHUNK=3, 4 pad bits).
//  1. Weight mem = in_vector for all neurons, T=20,20,20:
//     out_vector=3'b111; out_valid exactly 9 clocks after accept.
//  2. Weights = ~in_vector, T=1,0,21: out_vector=3'b010.
//  3. in_vector=0, weights=0, pad bits of wt_data driven 0:
//     T=20 -> 1, T=21 -> 0; padding is never counted (24 would be wrong).
//  4. Hold out_ready=0 for 5 cycles after out_valid, pulse in_valid meanwhile:
//     out_valid/out_vector stable, in_ready=0, pulse ignored.
//     Then out_ready=1 -> in_ready=1 the next cycle.
//  5. Deassert rst_n 4 cycles into ACCUM:
//     immediately out_valid=0, busy=0, out_vector=0, in_ready=1.
//     The next vector then completes correctly in 9 cycles.
//  6. With MLP_LAYER_SCORE_OUT_EN: neuron weights = in, ~in, in with low 10 bits flipped
//     -> scores = {10,0,20} (neuron 2..0); with T=10 each, out_vector=3'b101.

Source files
------------

// File: rtl/mlp_layer_tm.sv
// Time-multiplexed binary fully-connected layer.
// Neuron n fires when popcount(XNOR(in_vector, W[n])) >= T[n]. Each clock
// handles one CHUNK-wide weight word, so a vector takes NUM_NEURONS*NCHUNK
// clocks. Weights and thresholds come from external combinational storage.
// Optional build macro: MLP_LAYER_SCORE_OUT_EN adds the per-neuron 'scores' port.
module mlp_layer_tm #(
    parameter int INPUT_SIZE      = 784,
    parameter int NUM_NEURONS     = 10,
    parameter int CHUNK           = 16,
    parameter int THRESHOLD_WIDTH = $clog2(INPUT_SIZE + 1),
    localparam int NCHUNK         = (INPUT_SIZE + CHUNK - 1) / CHUNK,
    localparam int AW             = (NUM_NEURONS * NCHUNK > 1) ? $clog2(NUM_NEURONS * NCHUNK) : 1,
    localparam int NW             = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUT_SIZE-1:0]      in_vector,
    output logic [AW-1:0]              wt_addr,
    input  logic [CHUNK-1:0]           wt_data,
    output logic [NW-1:0]              thr_addr,
    input  logic [THRESHOLD_WIDTH-1:0] thr_data,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_NEURONS-1:0]     out_vector
`ifdef MLP_LAYER_SCORE_OUT_EN
    ,
    output logic [NUM_NEURONS*THRESHOLD_WIDTH-1:0] scores
`endif
);

    localparam int PADW     = NCHUNK * CHUNK;
    localparam int PAD_BITS = PADW - INPUT_SIZE;
    // Last chunk only keeps the low bits that map onto real inputs.
    localparam logic [CHUNK-1:0] LAST_MASK   = {CHUNK{1'b1}} >> PAD_BITS;
    localparam int               CW          = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST_CHUNK  = CW'(NCHUNK - 1);
    localparam logic [NW-1:0]    LAST_NEURON = NW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                           state;
    logic [NCHUNK-1:0][CHUNK-1:0]     in_words;
    logic [CW-1:0]                    chunk;
    logic [NW-1:0]                    neuron;
    logic [AW-1:0]                    addr;
    logic [THRESHOLD_WIDTH-1:0]       acc;
    logic [CHUNK-1:0]                 in_chunk;
    logic [CHUNK-1:0]                 mask;
    logic [CHUNK-1:0]                 match;
    logic [THRESHOLD_WIDTH-1:0]       partial;
    logic [THRESHOLD_WIDTH-1:0]       sum;
    logic                             fire;

    function automatic logic [THRESHOLD_WIDTH-1:0] popcount(input logic [CHUNK-1:0] bits);
        logic [THRESHOLD_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + THRESHOLD_WIDTH'(bits[i]);
        end
        return cnt;
    endfunction

    assign wt_addr  = addr;
    assign thr_addr = neuron;

    // XNOR-popcount of the current chunk and the running neuron total.
    always_comb begin
        in_chunk = in_words[chunk];
        mask     = (chunk == LAST_CHUNK) ? LAST_MASK : {CHUNK{1'b1}};
        match    = ~(in_chunk ^ wt_data) & mask;
        partial  = popcount(match);
        sum      = acc + partial;
        fire     = (sum >= thr_data);
    end

    // Input vector capture, zero-padded to a whole number of chunks.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            in_words <= PADW'(in_vector);
        end
    end

    // Control FSM: accept, walk neuron/chunk counters, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_vector <= '0;
            chunk      <= '0;
            neuron     <= '0;
            addr       <= '0;
            acc        <= '0;
`ifdef MLP_LAYER_SCORE_OUT_EN
            scores     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        chunk    <= '0;
                        neuron   <= '0;
                        addr     <= '0;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    addr <= addr + AW'(1);
                    if (chunk == LAST_CHUNK) begin
                        out_vector[neuron] <= fire;
`ifdef MLP_LAYER_SCORE_OUT_EN
                        scores[neuron*THRESHOLD_WIDTH +: THRESHOLD_WIDTH] <= sum;
`endif
                        acc   <= '0;
                        chunk <= '0;
                        if (neuron == LAST_NEURON) begin
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            neuron <= neuron + NW'(1);
                        end
                    end else begin
                        acc   <= sum;
                        chunk <= chunk + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_tm.sv
// Self-checking bench for mlp_layer_tm with INPUT_SIZE=20, NUM_NEURONS=3, CHUNK=8.
// Build macro MLP_LAYER_SCORE_OUT_EN additionally checks the scores port.
module tb_mlp_layer_tm;

    localparam int IS = 20;
    localparam int NN = 3;
    localparam int CK = 8;
    localparam int NC = 3;
    localparam int TW = 5;
    localparam int AW = 4;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [IS-1:0] in_vector;
    logic [AW-1:0] wt_addr;
    logic [CK-1:0] wt_data;
    logic [NW-1:0] thr_addr;
    logic [TW-1:0] thr_data;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [NN-1:0] out_vector;
`ifdef MLP_LAYER_SCORE_OUT_EN
    logic [NN*TW-1:0] scores;
`endif

    logic [IS-1:0]       wmem [NN];
    logic [TW-1:0]       thr  [NN];
    logic [NC*CK-IS-1:0] pad_bits;
    int                  mn;
    int                  mc;
    logic [NC*CK-1:0]    wpad;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mlp_layer_tm #(.INPUT_SIZE(IS), .NUM_NEURONS(NN), .CHUNK(CK)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_vector(in_vector),
        .wt_addr(wt_addr),
        .wt_data(wt_data),
        .thr_addr(thr_addr),
        .thr_data(thr_data),
        .busy(busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vector(out_vector)
`ifdef MLP_LAYER_SCORE_OUT_EN
        ,
        .scores(scores)
`endif
    );

    // External weight / threshold storage, combinational read, pad bits configurable.
    always_comb begin
        mn       = int'(wt_addr) / NC;
        mc       = int'(wt_addr) % NC;
        wt_data  = '0;
        wpad     = '0;
        thr_data = '0;
        if (mn < NN) begin
            wpad    = {pad_bits, wmem[mn]};
            wt_data = wpad[mc*CK +: CK];
        end
        if (int'(thr_addr) < NN) thr_data = thr[thr_addr];
    end

    // Reference: neuron fires when matching real input bits reach its threshold.
    function automatic logic [NN-1:0] model(input logic [IS-1:0] v);
        logic [NN-1:0] r;
        for (int n = 0; n < NN; n++) begin
            r[n] = ($countones(~(v ^ wmem[n])) >= int'(thr[n]));
        end
        return r;
    endfunction

    function automatic logic [NN*TW-1:0] model_scores(input logic [IS-1:0] v);
        logic [NN*TW-1:0] s;
        for (int n = 0; n < NN; n++) begin
            s[n*TW +: TW] = TW'($countones(~(v ^ wmem[n])));
        end
        return s;
    endfunction

    task automatic send_vec(input logic [IS-1:0] v, output int lat,
                            output logic busy_after, output logic rdy_after);
        in_vector = v;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        busy_after = busy;
        rdy_after  = in_ready;
        lat        = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_vector !== 3'b000) begin bad++; $display("FAIL rst_out_vector got=%b want=000", out_vector); end
        total++; if (wt_addr !== 4'd0) begin bad++; $display("FAIL rst_wt_addr got=%0d want=0", wt_addr); end
        total++; if (thr_addr !== 2'd0) begin bad++; $display("FAIL rst_thr_addr got=%0d want=0", thr_addr); end
`ifdef MLP_LAYER_SCORE_OUT_EN
        total++; if (scores !== '0) begin bad++; $display("FAIL rst_scores got=%h want=0", scores); end
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_idle got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy); end
    endtask

    task automatic test_match();
        logic [IS-1:0] v;
        int lat;
        logic b, r;
        for (int k = 0; k < 3; k++) begin
            v = IS'($urandom);
            pad_bits = 4'($urandom);
            for (int n = 0; n < NN; n++) begin wmem[n] = v; thr[n] = 5'd20; end
            send_vec(v, lat, b, r);
            total++; if (b !== 1'b1 || r !== 1'b0) begin bad++; $display("FAIL match_accum_flags got busy=%b rdy=%b want busy=1 rdy=0", b, r); end
            total++; if (lat !== 9) begin bad++; $display("FAIL match_latency got=%0d want=9", lat); end
            total++; if (out_vector !== 3'b111) begin bad++; $display("FAIL match_out got=%b want=111", out_vector); end
            drain();
            total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL match_release got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid); end
        end
    endtask

    task automatic test_inverse();
        logic [IS-1:0] v;
        int lat;
        logic b, r;
        v = IS'($urandom);
        pad_bits = 4'($urandom);
        for (int n = 0; n < NN; n++) wmem[n] = ~v;
        thr[0] = 5'd1; thr[1] = 5'd0; thr[2] = 5'd21;
        send_vec(v, lat, b, r);
        total++; if (out_vector !== 3'b010) begin bad++; $display("FAIL inverse_out got=%b want=010", out_vector); end
        drain();
    endtask

    task automatic test_padding();
        int lat;
        logic b, r;
        pad_bits = '0;
        for (int n = 0; n < NN; n++) wmem[n] = '0;
        thr[0] = 5'd20; thr[1] = 5'd21; thr[2] = 5'd20;
        send_vec('0, lat, b, r);
        total++; if (lat !== 9) begin bad++; $display("FAIL padding_latency got=%0d want=9", lat); end
        total++; if (out_vector !== 3'b101) begin bad++; $display("FAIL padding_out got=%b want=101", out_vector); end
`ifdef MLP_LAYER_SCORE_OUT_EN
        total++; if (scores !== {5'd20, 5'd20, 5'd20}) begin bad++; $display("FAIL padding_scores got=%h want=%h", scores, {5'd20, 5'd20, 5'd20}); end
`endif
        drain();
    endtask

    task automatic test_random();
        logic [IS-1:0] v;
        logic [NN-1:0] exp_out;
        int lat;
        logic b, r;
        for (int k = 0; k < 8; k++) begin
            v = IS'($urandom);
            pad_bits = 4'($urandom);
            for (int n = 0; n < NN; n++) begin
                wmem[n] = (k[0]) ? (v ^ IS'($urandom) & IS'($urandom)) : IS'($urandom);
                thr[n]  = TW'($urandom_range(0, 21));
            end
            exp_out = model(v);
            send_vec(v, lat, b, r);
            total++; if (lat !== 9) begin bad++; $display("FAIL random_latency got=%0d want=9", lat); end
            total++; if (out_vector !== exp_out) begin bad++; $display("FAIL random_out got=%b want=%b", out_vector, exp_out); end
`ifdef MLP_LAYER_SCORE_OUT_EN
            total++; if (scores !== model_scores(v)) begin bad++; $display("FAIL random_scores got=%h want=%h", scores, model_scores(v)); end
`endif
            drain();
        end
    endtask

    task automatic test_back_to_back();
        logic [IS-1:0] v;
        logic [NN-1:0] exp_out;
        int lat;
        logic b, r;
        v = IS'($urandom);
        pad_bits = 4'($urandom);
        for (int n = 0; n < NN; n++) begin
            wmem[n] = IS'($urandom);
            thr[n]  = TW'($urandom_range(5, 15));
        end
        exp_out = model(v);
        send_vec(v, lat, b, r);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin in_vector = ~v; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vector !== exp_out) begin
                bad++; $display("FAIL hold_stable cyc=%0d got ov=%b rdy=%b out=%b want ov=1 rdy=0 out=%b", i, out_valid, in_ready, out_vector, exp_out);
            end
        end
        in_valid = 1'b0;
        drain();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid); end
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_pulse_ignored got busy=%b rdy=%b want busy=0 rdy=1", busy, in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [IS-1:0] v;
        logic [NN-1:0] exp_out;
        int lat;
        logic b, r;
        v = IS'($urandom);
        for (int n = 0; n < NN; n++) begin wmem[n] = v; thr[n] = 5'd0; end
        in_vector = v;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1 || out_vector[0] !== 1'b1) begin bad++; $display("FAIL midrst_pre got busy=%b out0=%b want busy=1 out0=1", busy, out_vector[0]); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_vector !== 3'b000 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_state got ov=%b busy=%b out=%b rdy=%b want ov=0 busy=0 out=000 rdy=1", out_valid, busy, out_vector, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = IS'($urandom);
        for (int n = 0; n < NN; n++) begin
            wmem[n] = IS'($urandom);
            thr[n]  = TW'($urandom_range(6, 14));
        end
        exp_out = model(v);
        send_vec(v, lat, b, r);
        total++; if (lat !== 9) begin bad++; $display("FAIL midrst_latency got=%0d want=9", lat); end
        total++; if (out_vector !== exp_out) begin bad++; $display("FAIL midrst_out got=%b want=%b", out_vector, exp_out); end
        drain();
    endtask

    task automatic test_scores();
        logic [IS-1:0] v;
        int lat;
        logic b, r;
        v = IS'($urandom);
        pad_bits = 4'($urandom);
        wmem[0] = v;
        wmem[1] = ~v;
        wmem[2] = v ^ 20'h003FF;
        for (int n = 0; n < NN; n++) thr[n] = 5'd10;
        send_vec(v, lat, b, r);
        total++; if (out_vector !== 3'b101) begin bad++; $display("FAIL scores_out got=%b want=101", out_vector); end
`ifdef MLP_LAYER_SCORE_OUT_EN
        total++; if (scores !== {5'd10, 5'd0, 5'd20}) begin bad++; $display("FAIL scores_val got=%h want=%h", scores, {5'd10, 5'd0, 5'd20}); end
`endif
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vector = '0;
        pad_bits  = '0;
        for (int n = 0; n < NN; n++) begin wmem[n] = '0; thr[n] = '0; end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_match();
        test_inverse();
        test_padding();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_scores();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
